// File: rtl/key_led_pkg.sv
// Shared encodings and default timing constants for the key-driven LED mode controller.
package key_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_SYNC = 2'd1,
      MODE_ALT  = 2'd2,
      MODE_ON   = 2'd3
   } mode_e;

   localparam logic [1:0]  SPEED_MAX    = 2'd2;
   localparam logic [19:0] DEB_MAX_DEF  = 20'd1000000;
   localparam logic [24:0] TICK_MAX_DEF = 25'd25000000;

   function automatic logic [1:0] led_decode(input mode_e m, input logic ph);
      logic [1:0] r;
      r = 2'b00;
      case (m)
         MODE_OFF:  r = 2'b00;
         MODE_SYNC: r = {ph, ph};
         MODE_ALT:  r = {ph, ~ph};
         MODE_ON:   r = 2'b11;
         default:   r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, stable-count debouncer and a registered
// one-cycle pulse on each falling edge of the debounced level.
module key_debounce
   import key_led_pkg::*;
#(
   parameter logic [19:0] DEB_MAX = DEB_MAX_DEF
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic key_in,
   output logic key_db,
   output logic press
);

   logic        sync1_q, sync2_q;
   logic        db_q, db_d;
   logic        db_prev_q;
   logic [19:0] cnt_q, cnt_d;
   logic        press_q, press_d;

   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = db_prev_q & ~db_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_MAX - 20'd1) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 20'd1;
      end
   end

   // Idle level of the keys is 1, so the synchroniser and debounced level reset high.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         db_q      <= 1'b1;
         db_prev_q <= 1'b1;
         cnt_q     <= '0;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= key_in;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
      end
   end

   assign key_db = db_q;
   assign press  = press_q;

endmodule

// File: rtl/key_led_mode_ctrl.sv
// Mode/speed controller: key[0] steps the LED pattern, key[1] steps the blink
// rate; a tick counter toggles the blink phase every half-period.
module key_led_mode_ctrl
   import key_led_pkg::*;
#(
   parameter logic [19:0] DEB_MAX  = DEB_MAX_DEF,
   parameter logic [24:0] TICK_MAX = TICK_MAX_DEF
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic [1:0] key,
   output logic [1:0] led,
   output logic [1:0] mode,
   output logic [1:0] speed
);

   logic [1:0]  press;
   logic [1:0]  key_db_unused;

   mode_e       mode_q, mode_d;
   logic [1:0]  speed_q, speed_d;
   logic [1:0]  speed_eff;
   logic [24:0] half_per;
   logic [24:0] tick_q, tick_d;
   logic        phase_q, phase_d;
   logic [1:0]  led_q, led_d;

   key_debounce #(.DEB_MAX(DEB_MAX)) u_deb0 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .key_in  (key[0]),
      .key_db  (key_db_unused[0]),
      .press   (press[0])
   );

   key_debounce #(.DEB_MAX(DEB_MAX)) u_deb1 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .key_in  (key[1]),
      .key_db  (key_db_unused[1]),
      .press   (press[1])
   );

   // Speed code 3 is never loaded; if it appears it behaves as the base rate.
   always_comb begin
      speed_eff = (speed_q == 2'd3) ? 2'd0 : speed_q;
      half_per  = TICK_MAX >> speed_eff;
      mode_d    = mode_q;
      speed_d   = speed_q;
      tick_d    = tick_q;
      phase_d   = phase_q;
      led_d     = led_decode(mode_q, phase_q);
      if (press[0] || press[1]) begin
         tick_d = '0;
         if (press[0]) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            phase_d = 1'b0;
         end
         if (press[1]) begin
            speed_d = (speed_eff >= SPEED_MAX) ? 2'd0 : speed_eff + 2'd1;
         end
      end else if (tick_q == half_per - 25'd1) begin
         tick_d  = '0;
         phase_d = ~phase_q;
      end else begin
         tick_d = tick_q + 25'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= MODE_OFF;
         speed_q <= 2'd0;
         tick_q  <= '0;
         phase_q <= 1'b0;
         led_q   <= 2'b00;
      end else begin
         mode_q  <= mode_d;
         speed_q <= speed_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign led   = led_q;
   assign mode  = mode_q;
   assign speed = speed_q;

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Directed bench for key_led_mode_ctrl with DEB_MAX=4, TICK_MAX=16.
module tb_key_led_mode_ctrl;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic [1:0] key;
   logic [1:0] led;
   logic [1:0] mode;
   logic [1:0] speed;

   int n_cmp = 0;
   int n_bad = 0;

   key_led_mode_ctrl #(.DEB_MAX(20'd4), .TICK_MAX(25'd16)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .key     (key),
      .led     (led),
      .mode    (mode),
      .speed   (speed)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic press_release(input int b);
      key[b] = 1'b0;
      step(10);
      key[b] = 1'b1;
      step(10);
   endtask

   task automatic test_reset;
      step(3);
      n_cmp++;
      if ({led, mode, speed} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_hold: led/mode/speed=%b required 000000", {led, mode, speed});
      end
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(1);
         n_cmp++;
         if ({led, mode, speed} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_idle cyc%0d: led/mode/speed=%b required 000000", i, {led, mode, speed});
         end
      end
   endtask

   task automatic test_glitch;
      key[0] = 1'b0;
      step(3);
      key[0] = 1'b1;
      step(20);
      n_cmp++;
      if (mode !== 2'd0 || led !== 2'b00) begin
         n_bad++;
         $display("FAIL glitch: mode=%0d led=%b required mode=0 led=00", mode, led);
      end
   endtask

   task automatic test_mode_sync;
      logic [1:0] exp_led;
      key[0] = 1'b0;
      step(7);
      n_cmp++;
      if (mode !== 2'd0) begin
         n_bad++;
         $display("FAIL sync_edge7: mode=%0d required 0", mode);
      end
      step(1);
      n_cmp++;
      if (mode !== 2'd1 || led !== 2'b00) begin
         n_bad++;
         $display("FAIL sync_edge8: mode=%0d led=%b required mode=1 led=00", mode, led);
      end
      for (int k = 9; k <= 56; k++) begin
         step(1);
         if (k == 40) key[0] = 1'b1;
         exp_led = (((k - 9) / 16) % 2 == 1) ? 2'b11 : 2'b00;
         n_cmp++;
         if (led !== exp_led) begin
            n_bad++;
            $display("FAIL sync_blink edge%0d: led=%b required %b", k, led, exp_led);
         end
      end
      n_cmp++;
      if (mode !== 2'd1) begin
         n_bad++;
         $display("FAIL sync_single_event: mode=%0d required 1", mode);
      end
      step(10);
   endtask

   task automatic test_mode_wrap;
      // mode 1 -> 2 (ALT)
      key[0] = 1'b0;
      step(8);
      n_cmp++;
      if (mode !== 2'd2) begin
         n_bad++;
         $display("FAIL wrap_to2: mode=%0d required 2", mode);
      end
      step(1);
      n_cmp++;
      if (led !== 2'b01) begin
         n_bad++;
         $display("FAIL alt_first: led=%b required 01", led);
      end
      step(1);
      key[0] = 1'b1;
      step(14);
      n_cmp++;
      if (led !== 2'b01) begin
         n_bad++;
         $display("FAIL alt_edge24: led=%b required 01", led);
      end
      step(1);
      n_cmp++;
      if (led !== 2'b10) begin
         n_bad++;
         $display("FAIL alt_edge25: led=%b required 10", led);
      end
      // mode 2 -> 3 (ON)
      key[0] = 1'b0;
      step(8);
      n_cmp++;
      if (mode !== 2'd3) begin
         n_bad++;
         $display("FAIL wrap_to3: mode=%0d required 3", mode);
      end
      step(1);
      n_cmp++;
      if (led !== 2'b11) begin
         n_bad++;
         $display("FAIL on_first: led=%b required 11", led);
      end
      step(1);
      key[0] = 1'b1;
      step(15);
      n_cmp++;
      if (led !== 2'b11) begin
         n_bad++;
         $display("FAIL on_steady: led=%b required 11", led);
      end
      // mode 3 -> 0 (wrap)
      key[0] = 1'b0;
      step(7);
      n_cmp++;
      if (mode !== 2'd3) begin
         n_bad++;
         $display("FAIL wrap_edge7: mode=%0d required 3", mode);
      end
      step(1);
      n_cmp++;
      if (mode !== 2'd0) begin
         n_bad++;
         $display("FAIL wrap_to0: mode=%0d required 0", mode);
      end
      step(1);
      n_cmp++;
      if (led !== 2'b00) begin
         n_bad++;
         $display("FAIL off_after_wrap: led=%b required 00", led);
      end
      step(1);
      key[0] = 1'b1;
      step(10);
   endtask

   task automatic test_speed;
      logic [1:0] exp_led;
      int         per;
      press_release(0);
      key[0] = 1'b0;
      step(8);
      n_cmp++;
      if (mode !== 2'd2) begin
         n_bad++;
         $display("FAIL speed_setup: mode=%0d required 2", mode);
      end
      step(2);
      key[0] = 1'b1;
      for (int s = 1; s <= 3; s++) begin
         key[1] = 1'b0;
         step(7);
         n_cmp++;
         if (speed !== 2'(s - 1)) begin
            n_bad++;
            $display("FAIL speed_edge7 s%0d: speed=%0d required %0d", s, speed, s - 1);
         end
         step(1);
         n_cmp++;
         if (speed !== 2'(s % 3)) begin
            n_bad++;
            $display("FAIL speed_edge8 s%0d: speed=%0d required %0d", s, speed, s % 3);
         end
         per = (s == 1) ? 8 : (s == 2) ? 4 : 16;
         for (int i = 0; i < 2 * per; i++) begin
            step(1);
            exp_led = ((i / per) % 2 == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (led !== exp_led) begin
               n_bad++;
               $display("FAIL speed_blink s%0d i%0d: led=%b required %b", s, i, led, exp_led);
            end
         end
         key[1] = 1'b1;
         step(10);
      end
      n_cmp++;
      if (mode !== 2'd2) begin
         n_bad++;
         $display("FAIL speed_mode_kept: mode=%0d required 2", mode);
      end
   endtask

   task automatic test_simultaneous_and_reset;
      logic [1:0] exp_led;
      press_release(0);
      press_release(0);
      press_release(0);
      n_cmp++;
      if (mode !== 2'd1 || speed !== 2'd0) begin
         n_bad++;
         $display("FAIL simul_setup: mode=%0d speed=%0d required 1/0", mode, speed);
      end
      key = 2'b00;
      step(7);
      n_cmp++;
      if ({mode, speed} !== 4'b0100) begin
         n_bad++;
         $display("FAIL simul_edge7: mode=%0d speed=%0d required 1/0", mode, speed);
      end
      step(1);
      n_cmp++;
      if ({mode, speed} !== 4'b1001) begin
         n_bad++;
         $display("FAIL simul_edge8: mode=%0d speed=%0d required 2/1", mode, speed);
      end
      for (int i = 0; i < 16; i++) begin
         step(1);
         exp_led = (i >= 8) ? 2'b10 : 2'b01;
         n_cmp++;
         if (led !== exp_led) begin
            n_bad++;
            $display("FAIL simul_blink i%0d: led=%b required %b", i, led, exp_led);
         end
      end
      key[0] = 1'b1;
      step(3);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({led, mode, speed} !== 6'd0) begin
         n_bad++;
         $display("FAIL async_reset: led/mode/speed=%b required 000000", {led, mode, speed});
      end
      step(2);
      n_cmp++;
      if ({led, mode, speed} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_held: led/mode/speed=%b required 000000", {led, mode, speed});
      end
      rst = 1'b1;
      step(7);
      n_cmp++;
      if (speed !== 2'd0) begin
         n_bad++;
         $display("FAIL post_reset_edge7: speed=%0d required 0", speed);
      end
      step(1);
      n_cmp++;
      if (speed !== 2'd1 || mode !== 2'd0) begin
         n_bad++;
         $display("FAIL post_reset_edge8: speed=%0d mode=%0d required 1/0", speed, mode);
      end
      key[1] = 1'b1;
      step(10);
      n_cmp++;
      if (speed !== 2'd1 || led !== 2'b00) begin
         n_bad++;
         $display("FAIL post_reset_settle: speed=%0d led=%b required 1/00", speed, led);
      end
   endtask

   initial begin
      key = 2'b11;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      test_reset();
      test_glitch();
      test_mode_sync();
      test_mode_wrap();
      test_speed();
      test_simultaneous_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
